// File: rtl/dpram_burst_reader_pkg.sv
// Shared definitions for the dual-port RAM burst reader.
//   state_e        : burst controller FSM encoding
//   RdLatencyLow   : RAM read latency of the low-latency RAM flavour
//   RdLatencyHigh  : RAM read latency of the output-registered RAM flavour
package dpram_burst_reader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned RdLatencyLow  = 1;
    localparam int unsigned RdLatencyHigh = 2;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy count.
//   clk, rst : clock, asynchronous active-high reset (pointers and count)
//   push     : write wdata this cycle (caller guarantees not full)
//   wdata    : write data
//   pop      : consume head entry this cycle (caller guarantees not empty)
//   rdata    : head entry, valid while !empty, stable until popped
//   empty    : no entries held
//   count    : number of entries held (0..DEPTH)
module dma_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dpram_burst_reader.sv
// Read-side burst initiator for one dual-port RAM port.
// Takes a (start_addr, start_len) command, issues back-to-back RAM reads under a credit limit,
// realigns returned words with a tag pipe matching the RAM read latency, buffers them and
// presents them on a valid/ready stream with the last word marked.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : command strobe, accepted only when idle
//   start_addr        : first word address
//   start_len         : word count, 0 = empty burst
//   busy              : from cycle after accepted start through the done pulse
//   done              : one-cycle pulse when the burst is fully issued and drained
//   ram_en, ram_addr  : RAM read strobe and address
//   ram_dout          : RAM read data, RD_LATENCY cycles after ram_en
//   m_valid, m_data,
//   m_last, m_ready   : output stream
module dpram_burst_reader
    import dpram_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 9,
    localparam int unsigned AW        = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         start_addr,
    input  logic [LEN_W-1:0]      start_len,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [AW-1:0]         ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic [RD_LATENCY-1:0] tag_vld_q, tag_last_q;
    logic [CW:0]           inflight;
    logic [CW:0]           occupancy;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_rdata;
    logic                  credit_ok, issue, issue_last, pop;

    // Credits cover both buffered words and words still inside the RAM pipe; a pop in the
    // same cycle is deliberately not counted as freeing a slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {{CW{1'b0}}, tag_vld_q[i]};
        end
    end

    assign occupancy  = {1'b0, fifo_count} + inflight;
    assign credit_ok  = (occupancy < (CW+1)'(FIFO_DEPTH));
    assign issue      = (state_q == StRun) && credit_ok;
    assign issue_last = issue && (rem_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = start_len;
                    state_d = (start_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    // AW-bit increment wraps RAM_DEPTH-1 to 0.
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fifo_empty && (inflight == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // Tag pipe runs in lockstep with the RAM read pipe; the tag emerging at the far end marks
    // the cycle in which ram_dout belongs to one of our reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
        end else begin
            tag_vld_q[0]  <= issue;
            tag_last_q[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    assign pop = m_valid && m_ready;

    dma_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_vld_q[RD_LATENCY-1]),
        .wdata ({tag_last_q[RD_LATENCY-1], ram_dout}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign ram_en   = issue;
    assign ram_addr = addr_q;
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_rdata[DATA_WIDTH-1:0];
    assign m_last   = fifo_rdata[DATA_WIDTH] && !fifo_empty;

endmodule
